// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI memory arbiter: FSM state encoding,
// transfer size codes, transfer length table and the byte-order helpers
// that convert between the master's MSB-first shift order and the CPU's
// little-endian view.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DXFER,
    ST_STREAM,
    ST_STOP
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [5:0] LEN_BYTE = 6'd8;
  localparam logic [5:0] LEN_HALF = 6'd16;
  localparam logic [5:0] LEN_WORD = 6'd32;

  // Size code 3 is treated as a word.
  function automatic logic [5:0] len_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: return LEN_BYTE;
      SZ_HALF: return LEN_HALF;
      default: return LEN_WORD;
    endcase
  endfunction

  // The first byte fetched lands in raw[31:24]; its two low bits tell
  // a compressed (16-bit) instruction from a full 32-bit one.
  function automatic logic is_rvc(input logic [31:0] raw);
    return raw[25:24] != 2'b11;
  endfunction

  function automatic logic [31:0] fmt_instr(input logic [31:0] raw);
    if (is_rvc(raw))
      return {16'h0000, raw[23:16], raw[31:24]};
    return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
  endfunction

  // Store data goes out left-aligned with the lowest-address byte first.
  function automatic logic [31:0] fmt_store(input logic [31:0] w, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {w[7:0], 24'h000000};
      SZ_HALF: return {w[7:0], w[15:8], 16'h0000};
      default: return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endcase
  endfunction

  // Load data arrives right-aligned; swap only the bytes actually read.
  function automatic logic [31:0] fmt_load(input logic [31:0] r, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {24'h000000, r[7:0]};
      SZ_HALF: return {16'h0000, r[7:0], r[15:8]};
      default: return {r[7:0], r[15:8], r[23:16], r[31:24]};
    endcase
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store ports, the arbiter and the
// SPI master.
//   if_*  : instruction-fetch port (req/addr/flush in, ready/rdata out)
//   d_*   : load/store port (req/we/size/addr/wdata in, ready/rdata out)
//   m_*   : SPI master controls/operands (out) and result/done (in)
// slave  : the arbiter's view.  master : the CPU + SPI master side.
interface spi_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic [31:0]       d_rdata;

  logic              m_start;
  logic              m_stop;
  logic              m_cont;
  logic              m_write_enable;
  logic              m_is_instr;
  logic [ADDR_W-1:0] m_addr;
  logic [5:0]        m_data_len;
  logic [31:0]       m_data_in;
  logic [31:0]       m_data_out;
  logic              m_done;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    input  m_data_out, m_done,
    output if_ready, if_rdata, d_ready, d_rdata,
    output m_start, m_stop, m_cont, m_write_enable, m_is_instr,
    output m_addr, m_data_len, m_data_in
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_size, d_addr, d_wdata,
    output m_data_out, m_done,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  m_start, m_stop, m_cont, m_write_enable, m_is_instr,
    input  m_addr, m_data_len, m_data_in
  );
endinterface

// File: rtl/spi_fetch_buf.sv
// One-entry prefetch buffer holding an already little-endian instruction
// and the byte address it was fetched from.
//   load/load_addr/load_instr : capture a new entry
//   invalidate                : drop the entry (wins over load)
//   lookup_addr/hit/instr     : combinational hit check and stored word
module spi_fetch_buf #(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_instr,
  input  logic              invalidate,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [31:0]       instr
);

  logic              valid;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      instr <= '0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      instr <= load_instr;
    end
  end

  assign hit = valid && (addr == lookup_addr);

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one single-lane SPI master between the instruction-fetch port and
// the load/store port.  Data accesses are single start/done transfers;
// fetches open a stream that stays open across sequential fetches and is
// closed with a stop pulse.  One instruction that arrives with nobody
// waiting for it is parked in a prefetch buffer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spi_mem_arbiter_if.slave (CPU ports + SPI master controls)
module spi_mem_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter bit          DATA_PRIO = 1'b1
) (
  input logic              clk,
  input logic              rst,
  spi_mem_arbiter_if.slave bus
);

  arb_state_t        state, state_nxt;

  logic              op_we, op_instr;
  logic [ADDR_W-1:0] op_addr;
  logic [5:0]        op_len;
  logic [31:0]       op_wdata;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] exp_addr;
  logic              prefer_data;

  logic              if_ready_q, d_ready_q;
  logic [31:0]       if_rdata_q, d_rdata_q;

  logic              if_req_eff, d_req_eff, if_match;
  logic              buf_hit;
  logic [31:0]       buf_instr;
  logic              hit_now, grant_data, grant_fetch;
  logic              stream_break, stream_deliver, stream_park;
  logic [31:0]       instr_le;
  logic [ADDR_W-1:0] instr_step;

  // A request whose ready pulse is on the bus right now is being retired;
  // ignoring it for that cycle keeps it from being served twice.
  assign if_req_eff = bus.if_req && !if_ready_q;
  assign d_req_eff  = bus.d_req && !d_ready_q;
  assign if_match   = bus.if_addr == exp_addr;

  assign instr_le   = fmt_instr(bus.m_data_out);
  assign instr_step = is_rvc(bus.m_data_out) ? ADDR_W'(2) : ADDR_W'(4);

  // IDLE decisions: flush blocks everything for one cycle, a buffer hit
  // needs no master, otherwise alternate grants when both ports wait.
  assign hit_now     = (state == ST_IDLE) && !bus.if_flush && if_req_eff && buf_hit;
  assign grant_data  = (state == ST_IDLE) && !bus.if_flush && !hit_now && d_req_eff &&
                       (!if_req_eff || prefer_data);
  assign grant_fetch = (state == ST_IDLE) && !bus.if_flush && !hit_now && if_req_eff &&
                       !grant_data;

  // STREAM decisions.  A done that coincides with a break is still parked
  // in the buffer; a flush discards it.
  assign stream_break   = (state == ST_STREAM) && !bus.if_flush &&
                          (d_req_eff || (if_req_eff && !if_match));
  assign stream_deliver = (state == ST_STREAM) && !bus.if_flush && !stream_break &&
                          bus.m_done && if_req_eff;
  assign stream_park    = (state == ST_STREAM) && !bus.if_flush && bus.m_done &&
                          !stream_deliver;

  spi_fetch_buf #(.ADDR_W(ADDR_W)) u_fetch_buf (
    .clk         (clk),
    .rst         (rst),
    .load        (stream_park),
    .load_addr   (exp_addr),
    .load_instr  (instr_le),
    .invalidate  (bus.if_flush || grant_fetch || hit_now),
    .lookup_addr (bus.if_addr),
    .hit         (buf_hit),
    .instr       (buf_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_data || grant_fetch) state_nxt = ST_START;
      ST_START: begin
        if (op_instr && bus.if_flush) state_nxt = ST_STOP;
        else if (op_instr)            state_nxt = ST_STREAM;
        else                          state_nxt = ST_DXFER;
      end
      ST_DXFER:  if (bus.m_done) state_nxt = ST_IDLE;
      ST_STREAM: if (bus.if_flush || stream_break || stream_park) state_nxt = ST_STOP;
      ST_STOP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.m_start = 1'b0;
    bus.m_stop  = 1'b0;
    bus.m_cont  = 1'b0;
    case (state)
      ST_START: bus.m_start = 1'b1;
      ST_STOP:  bus.m_stop  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_we       <= 1'b0;
      op_instr    <= 1'b0;
      op_addr     <= '0;
      op_len      <= '0;
      op_wdata    <= '0;
      op_size     <= SZ_BYTE;
      exp_addr    <= '0;
      prefer_data <= DATA_PRIO;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;

      if (grant_data) begin
        op_we    <= bus.d_we;
        op_instr <= 1'b0;
        op_addr  <= bus.d_addr;
        op_len   <= len_of(bus.d_size);
        op_size  <= bus.d_size;
        op_wdata <= bus.d_we ? fmt_store(bus.d_wdata, bus.d_size) : '0;
      end

      if (grant_fetch) begin
        op_we    <= 1'b0;
        op_instr <= 1'b1;
        op_addr  <= bus.if_addr;
        op_len   <= LEN_WORD;
        op_size  <= SZ_WORD;
        op_wdata <= '0;
        exp_addr <= bus.if_addr;
      end

      if (hit_now) begin
        if_ready_q  <= 1'b1;
        if_rdata_q  <= buf_instr;
        prefer_data <= 1'b1;
      end

      if ((state == ST_DXFER) && bus.m_done) begin
        d_ready_q   <= 1'b1;
        d_rdata_q   <= fmt_load(bus.m_data_out, op_size);
        prefer_data <= 1'b0;
      end

      if ((state == ST_STREAM) && bus.m_done)
        exp_addr <= exp_addr + instr_step;

      if (stream_deliver) begin
        if_ready_q  <= 1'b1;
        if_rdata_q  <= instr_le;
        prefer_data <= 1'b1;
      end
    end
  end

  assign bus.m_write_enable = op_we;
  assign bus.m_is_instr     = op_instr;
  assign bus.m_addr         = op_addr;
  assign bus.m_data_len     = op_len;
  assign bus.m_data_in      = op_wdata;
  assign bus.if_ready       = if_ready_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.d_ready        = d_ready_q;
  assign bus.d_rdata        = d_rdata_q;

endmodule
